// File: rtl/arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded owner index,
// hold-limit revocation and a fixed RELEASE gap between owners.
module arbiter4 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic done,
  output logic grant0,
  output logic grant1,
  output logic grant2,
  output logic grant3,
  output logic address0,
  output logic address1,
  output logic enable,
  output logic busy,
  output logic timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [1:0]       r_addr, w_addr_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [3:0]       r_grant, w_grant_nxt;
  logic             r_enable, w_enable_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [3:0] w_req;
  logic [1:0] w_idx;
  logic [1:0] w_winner;
  logic       w_any;
  logic       w_own_req;
  logic       w_hold_max;
  logic       w_release;

  assign w_req      = {req3, req2, req1, req0};
  assign w_own_req  = w_req[r_addr];
  assign w_hold_max = (r_count == HOLD_LIM);
  assign w_release  = done | ~w_own_req | w_hold_max;

  // Rotating priority: scan from ptr back to ptr+1 so the nearest index after ptr wins last.
  always_comb begin
    w_winner = r_ptr;
    w_any    = 1'b0;
    w_idx    = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_ptr + 2'(k);
      if (w_req[w_idx]) begin
        w_winner = w_idx;
        w_any    = 1'b1;
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_addr_nxt    = r_addr;
    w_count_nxt   = r_count;
    w_enable_nxt  = 1'b0;
    w_busy_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt  = S_GRANT;
          w_ptr_nxt    = w_winner;
          w_addr_nxt   = w_winner;
          w_count_nxt  = CNT_W'(1);
          w_enable_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
        end
      end
      S_GRANT: begin
        w_busy_nxt = 1'b1;
        if (w_release) begin
          w_state_nxt   = S_RELEASE;
          w_timeout_nxt = w_hold_max & ~done & w_own_req;
        end else begin
          w_enable_nxt = 1'b1;
          if (r_count != {CNT_W{1'b1}}) begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    w_grant_nxt = w_enable_nxt ? (4'b0001 << w_addr_nxt) : 4'b0000;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd3;
      r_addr    <= 2'd0;
      r_count   <= '0;
      r_grant   <= 4'b0000;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_addr    <= w_addr_nxt;
      r_count   <= w_count_nxt;
      r_grant   <= w_grant_nxt;
      r_enable  <= w_enable_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign grant0   = r_grant[0];
  assign grant1   = r_grant[1];
  assign grant2   = r_grant[2];
  assign grant3   = r_grant[3];
  assign address0 = r_addr[0];
  assign address1 = r_addr[1];
  assign enable   = r_enable;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_arbiter4.sv
// Bench for arbiter4: directed scenarios plus random traffic against an
// owner/gap-based reference model of the round-robin grant sequencer.
module tb_arbiter4;

  localparam int MAXH = 4;

  logic       clk;
  logic       resetn;
  logic [3:0] req;
  logic       done;
  logic       grant0, grant1, grant2, grant3;
  logic       address0, address1, enable, busy, timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource, how long, and whether a gap cycle is pending.
  int   m_owner;
  int   m_addr;
  int   m_ptr;
  int   m_hold;
  logic m_rel;
  logic m_to;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arbiter4 #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
    .done(done),
    .grant0(grant0), .grant1(grant1), .grant2(grant2), .grant3(grant3),
    .address0(address0), .address1(address1),
    .enable(enable), .busy(busy), .timeout(timeout)
  );

  function automatic logic [8:0] dut_vec();
    return {grant3, grant2, grant1, grant0, address1, address0, enable, busy, timeout};
  endfunction

  function automatic logic [8:0] mdl_vec();
    logic [3:0] g;
    logic [1:0] a;
    logic       own;
    g   = 4'b0000;
    a   = 2'(m_addr);
    own = (m_owner >= 0);
    if (own) g[m_owner] = 1'b1;
    return {g, a, own, own | m_rel, m_to};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_addr  = 0;
    m_ptr   = 3;
    m_hold  = 0;
    m_rel   = 1'b0;
    m_to    = 1'b0;
  endtask

  // Advance the model on the current inputs, then clock the DUT and settle.
  task automatic step();
    logic to_n;
    int   w;
    to_n = 1'b0;
    if (m_owner >= 0) begin
      if (done || !req[m_owner] || m_hold == MAXH) begin
        to_n    = (m_hold == MAXH) && !done && req[m_owner];
        m_owner = -1;
        m_rel   = 1'b1;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
        m_addr  = w;
        m_hold  = 1;
      end
    end
    m_to = to_n;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    req  = 4'b0000;
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL idle_prep got %b exp %b", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_reset();
    req    = 4'b0000;
    done   = 1'b0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 9'b0) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", dut_vec(), 9'b0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    step();
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      done = (m_owner >= 0);
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL rr_cycle%0d got %b exp %b", i, dut_vec(), mdl_vec());
      end
      if (enable) order.push_back(int'({address1, address0}));
    end
    checks++;
    if (order.size() < 5) begin
      errors++;
      $display("FAIL rr_count got %0d exp >=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          errors++;
          $display("FAIL rr_order%0d got %0d exp %0d", i, order[i], exp_order[i]);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_single_req();
    go_idle();
    req = 4'b0100;
    step();
    checks++;
    if ({grant3, grant2, grant1, grant0, address1, address0, busy} !== 7'b0100_10_1) begin
      errors++;
      $display("FAIL single_grant got %b exp %b",
               {grant3, grant2, grant1, grant0, address1, address0, busy}, 7'b0100_10_1);
    end
    done = 1'b1;
    step();
    checks++;
    if (dut_vec() !== mdl_vec() || grant2 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_release got %b exp %b", dut_vec(), mdl_vec());
    end
    done = 1'b0;
    req  = 4'b0000;
    step();
    checks++;
    if (dut_vec() !== mdl_vec() || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got %b exp %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_hold_limit();
    logic [7:0] g1, to;
    go_idle();
    req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL hold_cycle%0d got %b exp %b", i, dut_vec(), mdl_vec());
      end
      g1[i] = grant1;
      to[i] = timeout;
    end
    checks++;
    if (g1 !== 8'b1100_1111 || to !== 8'b0001_0000) begin
      errors++;
      $display("FAIL hold_pattern got g=%b t=%b exp g=%b t=%b", g1, to, 8'b1100_1111, 8'b0001_0000);
    end
    go_idle();
  endtask

  task automatic test_done_at_limit();
    go_idle();
    req = 4'b0010;
    for (int i = 1; i <= 5; i++) begin
      done = (i == 5);
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL done_lim_cycle%0d got %b exp %b", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (timeout !== 1'b0 || grant1 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_beats_timeout got t=%b g=%b b=%b exp t=0 g=0 b=1", timeout, grant1, busy);
    end
    go_idle();
  endtask

  task automatic test_owner_drop();
    logic [2:0] exp_g0 = 3'b100;
    go_idle();
    req = 4'b1000;
    step();
    checks++;
    if (grant3 !== 1'b1) begin
      errors++;
      $display("FAIL drop_grant3 got %b exp 1", grant3);
    end
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec() !== mdl_vec() || grant0 !== exp_g0[i] || timeout !== 1'b0 || grant3 !== 1'b0) begin
        errors++;
        $display("FAIL drop_cycle%0d got %b exp %b (grant0 exp %b)", i, dut_vec(), mdl_vec(), exp_g0[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    go_idle();
    req = 4'b0100;
    step();
    checks++;
    if (grant2 !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got %b exp 1", grant2);
    end
    #3 resetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 9'b0) begin
      errors++;
      $display("FAIL areset_immediate got %b exp %b", dut_vec(), 9'b0);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    req = 4'b0101;
    step();
    checks++;
    if (dut_vec() !== mdl_vec() || grant0 !== 1'b1) begin
      errors++;
      $display("FAIL areset_first_winner got %b exp %b", dut_vec(), mdl_vec());
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d req=%b got %b exp %b", i, req, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_single_req();
    test_hold_limit();
    test_done_at_limit();
    test_owner_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
